// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A winner keeps the transmitter until its last byte or an idle timeout; one registered tx byte slot.
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_req,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int          ID_W       = $clog2(NUM_REQ);
    localparam int unsigned NUM_U      = NUM_REQ;
    localparam int          CNT_W      = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit          TIMEOUT_EN = (IDLE_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_TIMEOUT);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  idle_cnt_reg, idle_cnt_next;
    logic              tx_req_reg, tx_req_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic              timeout_err_reg, timeout_err_next;

    logic [ID_W-1:0]   rot_idx [NUM_REQ];
    logic [ID_W-1:0]   sel_id;
    logic              slot_free;
    logic              accept;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned   off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_U) begin
            sum = sum - NUM_U;
        end
        return ID_W'(sum);
    endfunction

    // rot_idx[k] is the requester examined k-th when searching from rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot_idx[gi] = wrap_add(rr_ptr_reg, 32'(gi));
        end
    endgenerate

    // Descending scan so the closest valid requester after rr_ptr wins.
    always_comb begin
        sel_id = rr_ptr_reg;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rot_idx[k]]) begin
                sel_id = rot_idx[k];
            end
        end
    end

    assign slot_free = !tx_req_reg || tx_ready;

    always_comb begin
        state_next       = state_reg;
        grant_id_next    = grant_id_reg;
        rr_ptr_next      = rr_ptr_reg;
        idle_cnt_next    = idle_cnt_reg;
        tx_req_next      = tx_req_reg;
        tx_data_next     = tx_data_reg;
        timeout_err_next = 1'b0;
        req_ready        = '0;
        accept           = 1'b0;

        // The transmit slot drains regardless of who owns the arbiter.
        if (tx_req_reg && tx_ready) begin
            tx_req_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next    = OWN;
                    grant_id_next = sel_id;
                    idle_cnt_next = '0;
                end
            end
            OWN: begin
                req_ready[grant_id_reg] = slot_free;
                accept = req_valid[grant_id_reg] && slot_free;
                if (accept) begin
                    tx_req_next   = 1'b1;
                    tx_data_next  = req_data[grant_id_reg*8 +: 8];
                    idle_cnt_next = '0;
                    if (req_last[grant_id_reg]) begin
                        state_next  = IDLE;
                        rr_ptr_next = wrap_add(grant_id_reg, 1);
                    end
                end else if (TIMEOUT_EN && !req_valid[grant_id_reg]) begin
                    // Only a missing byte counts as idle; stalled-but-valid cycles do not.
                    if (idle_cnt_reg != CNT_MAX) begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                    if (idle_cnt_reg == CNT_LAST) begin
                        state_next       = IDLE;
                        rr_ptr_next      = wrap_add(grant_id_reg, 1);
                        timeout_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg       <= IDLE;
            grant_id_reg    <= '0;
            rr_ptr_reg      <= '0;
            idle_cnt_reg    <= '0;
            tx_req_reg      <= 1'b0;
            tx_data_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_id_reg    <= grant_id_next;
            rr_ptr_reg      <= rr_ptr_next;
            idle_cnt_reg    <= idle_cnt_next;
            tx_req_reg      <= tx_req_next;
            tx_data_reg     <= tx_data_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign grant_valid = (state_reg == OWN);
    assign grant_id    = grant_id_reg;
    assign tx_req      = tx_req_reg;
    assign tx_data     = tx_data_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: expected transmit bytes go into a queue as stimulus is issued and are
// popped by a monitor on every downstream transfer; scenario tasks check grant/handshake timing.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int TOUT = 8;

    logic              clk = 1'b0;
    logic              reset_ = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_req;
    logic              tx_ready = 1'b1;
    logic [7:0]        tx_data;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              timeout_err;

    logic       v [NREQ] = '{default: 1'b0};
    logic [7:0] d [NREQ] = '{default: 8'h00};
    logic       l [NREQ] = '{default: 1'b0};

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign req_valid[gi]          = v[gi];
            assign req_data[gi*8 +: 8]    = d[gi];
            assign req_last[gi]           = l[gi];
        end
    endgenerate

    uart_tx_arb #(
        .NUM_REQ      (NREQ),
        .IDLE_TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_req      (tx_req),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Downstream monitor: each cycle with tx_req && tx_ready is one transferred byte.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (reset_ && tx_req && tx_ready) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL tx_byte unexpected got %02h exp none", tx_data);
            end else begin
                exp_b = sb.pop_front();
                if (tx_data !== exp_b) begin
                    errors = errors + 1;
                    $display("FAIL tx_byte got %02h exp %02h", tx_data, exp_b);
                end else begin
                    $display("tx byte %02h ok", tx_data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 just after the byte is accepted.
    task automatic send_byte(input int id, input logic [7:0] b, input logic last);
        int n;
        v[id] = 1'b1;
        d[id] = b;
        l[id] = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 200);
        if (!req_ready[id]) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_wait id %0d got req_ready=0 exp 1", id);
        end
        @(posedge clk);
        #1;
        v[id] = 1'b0;
        l[id] = 1'b0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            l[i] = 1'b0;
        end
        tx_ready = 1'b1;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks = checks + 1;
        if ({tx_req, grant_valid, timeout_err} !== 3'b000 || tx_data !== 8'h00 ||
            grant_id !== 2'd0 || req_ready !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL reset_outputs got req=%b gv=%b to=%b data=%02h gid=%0d rdy=%b exp all 0",
                     tx_req, grant_valid, timeout_err, tx_data, grant_id, req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (grant_valid !== 1'b0 || req_ready !== 4'b0000 || tx_req !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_idle got gv=%b rdy=%b req=%b exp 0 0000 0", grant_valid, req_ready, tx_req);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_msg();
        do_reset();
        sb.push_back(8'h41);
        sb.push_back(8'h42);
        sb.push_back(8'h43);
        v[1] = 1'b1; d[1] = 8'h41; l[1] = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (grant_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL single_no_grant_yet got %b exp 0", grant_valid);
        end
        @(negedge clk);
        checks = checks + 1;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1 || req_ready !== 4'b0010 || tx_req !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL single_grant got gv=%b gid=%0d rdy=%b req=%b exp 1 1 0010 0",
                     grant_valid, grant_id, req_ready, tx_req);
        end
        @(posedge clk); #1; d[1] = 8'h42;
        @(negedge clk);
        checks = checks + 1;
        if (tx_req !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_tx_latency got tx_req=%b exp 1", tx_req);
        end
        @(posedge clk); #1; d[1] = 8'h43; l[1] = 1'b1;
        @(posedge clk); #1; v[1] = 1'b0; l[1] = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (grant_valid !== 1'b0 || req_ready !== 4'b0000 || tx_req !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_release got gv=%b rdy=%b req=%b exp 0 0000 1", grant_valid, req_ready, tx_req);
        end
        @(negedge clk);
        checks = checks + 1;
        if (tx_req !== 1'b0 || tx_data !== 8'h43) begin
            errors = errors + 1;
            $display("FAIL single_hold got req=%b data=%02h exp 0 43", tx_req, tx_data);
        end
        // rr_ptr is now 2, so requester 2 beats requester 0.
        @(posedge clk); #1;
        sb.push_back(8'h55);
        sb.push_back(8'h50);
        fork
            send_byte(2, 8'h55, 1'b1);
            send_byte(0, 8'h50, 1'b1);
        join
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL single_drain got %0d left exp 0", sb.size());
        end
        $display("test_single_msg done");
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'hA0 + 8'(i));
            sb.push_back(8'hC0 + 8'(i));
        end
        fork
            begin
                for (int i = 0; i < 3; i++) send_byte(0, 8'hA0 + 8'(i), 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) send_byte(2, 8'hC0 + 8'(i), 1'b1);
            end
            begin
                int   seen;
                logic prev;
                seen = 0;
                prev = 1'b0;
                for (int c = 0; c < 80 && seen < 6; c++) begin
                    @(negedge clk);
                    if (grant_valid && !prev) begin
                        checks = checks + 1;
                        if (grant_id !== 2'((seen % 2) * 2)) begin
                            errors = errors + 1;
                            $display("FAIL fair_grant_%0d got %0d exp %0d", seen, grant_id, (seen % 2) * 2);
                        end else begin
                            $display("grant %0d to %0d ok", seen, grant_id);
                        end
                        seen++;
                    end
                    prev = grant_valid;
                end
                if (seen < 6) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL fair_count got %0d exp 6", seen);
                end
            end
        join
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL fair_drain got %0d left exp 0", sb.size());
        end
        $display("test_fairness done");
    endtask

    task automatic test_no_interleave();
        bit done;
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back(8'hB0 + 8'(i));
        sb.push_back(8'hD1);
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_byte(0, 8'hB0 + 8'(i), i == 3);
            end
            send_byte(1, 8'hD1, 1'b1);
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (grant_valid && grant_id == 2'd0) begin
                        checks = checks + 1;
                        if (req_ready[1] !== 1'b0) begin
                            errors = errors + 1;
                            $display("FAIL nointer_ready1 got %b exp 0", req_ready[1]);
                        end
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL nointer_drain got %0d left exp 0", sb.size());
        end
        $display("test_no_interleave done");
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        sb.push_back(8'hE0);
        sb.push_back(8'hE1);
        send_byte(2, 8'hE0, 1'b0);
        tx_ready = 1'b0;
        v[2] = 1'b1; d[2] = 8'hE1; l[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks = checks + 1;
            if (tx_req !== 1'b1 || tx_data !== 8'hE0 || req_ready !== 4'b0000 ||
                timeout_err !== 1'b0 || grant_valid !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL bp_cycle_%0d got req=%b data=%02h rdy=%b to=%b gv=%b exp 1 e0 0000 0 1",
                         c, tx_req, tx_data, req_ready, timeout_err, grant_valid);
            end
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[2] && n < 50);
        checks = checks + 1;
        if (!req_ready[2]) begin
            errors = errors + 1;
            $display("FAIL bp_resume got req_ready=0 exp 1");
        end
        @(posedge clk); #1;
        v[2] = 1'b0; l[2] = 1'b0;
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL bp_drain got %0d left exp 0", sb.size());
        end
        $display("test_backpressure done");
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        sb.push_back(8'hF0);
        send_byte(3, 8'hF0, 1'b0);
        // Idle cycles 1..8 follow the accept; the pulse is registered after the eighth.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err && k < 30);
        checks = checks + 1;
        if (k != TOUT + 1) begin
            errors = errors + 1;
            $display("FAIL timeout_delay got %0d exp %0d", k, TOUT + 1);
        end
        checks = checks + 1;
        if (grant_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL timeout_grant got %b exp 0", grant_valid);
        end
        @(negedge clk);
        checks = checks + 1;
        if (timeout_err !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL timeout_pulse_width got %b exp 0", timeout_err);
        end
        // rr_ptr is now 0: requester 0 beats requester 3.
        @(posedge clk); #1;
        sb.push_back(8'h60);
        sb.push_back(8'hF1);
        fork
            send_byte(3, 8'hF1, 1'b1);
            send_byte(0, 8'h60, 1'b1);
        join
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL timeout_drain got %0d left exp 0", sb.size());
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb.push_back(8'h72);
        send_byte(2, 8'h72, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        send_byte(1, 8'h80, 1'b0);
        v[1] = 1'b1; d[1] = 8'h81;
        @(negedge clk);
        checks = checks + 1;
        if (tx_req !== 1'b1 || grant_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL rstmid_pre got req=%b gv=%b exp 1 1", tx_req, grant_valid);
        end
        #2;
        reset_ = 1'b0;
        #1;
        checks = checks + 1;
        if (tx_req !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'b0000 || timeout_err !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rstmid_async got req=%b gv=%b rdy=%b to=%b exp 0 0 0000 0",
                     tx_req, grant_valid, req_ready, timeout_err);
        end
        v[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
        tx_ready = 1'b1;
        // A stale rr_ptr of 3 would pick requester 3 first.
        sb.push_back(8'h91);
        sb.push_back(8'h93);
        fork
            send_byte(1, 8'h91, 1'b1);
            send_byte(3, 8'h93, 1'b1);
        join
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL rstmid_drain got %0d left exp 0", sb.size());
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_fairness();
        test_no_interleave();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, such as a debug console, a status reporter and a CDMA modem pass-through.
- Arbitration is round-robin at message granularity. Once a requester wins, it keeps the transmitter until it sends a byte flagged last, or until it goes idle for longer than IDLE_TIMEOUT.
- Bytes from different requesters are never interleaved on the wire.
- The downstream side uses the same req/ready handshake as the UART byte interfaces: tx_req is held high until tx_ready is sampled high.

Parameters:
- NUM_REQ, 4: number of requesters. Legal range 2..8.
- IDLE_TIMEOUT, 1024: maximum consecutive cycles a granted requester may hold req_valid low mid-message. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset_  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte. Requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of its message.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] && req_ready[i].
- tx_req  out  1  byte pending to the UART transmitter.
- tx_ready  in  1  transmitter accepts tx_data in this cycle.
- tx_data  out  8  byte to transmit. Stable while tx_req=1.
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  $clog2(NUM_REQ)  index of the owner.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (asynchronous, reset_=0):
  - Outputs: tx_req=0, tx_data=0, grant_valid=0, grant_id=0, timeout_err=0, req_ready=0.
  - Internal state: rr_ptr=0, idle counter=0, state=IDLE.
  - Reset mid-message drops any pending byte and the grant, with no error flagged.
- States: IDLE and OWN.
- IDLE:
  - req_ready is all zeros.
  - If any req_valid bit is set, select the first set bit searching from rr_ptr upward with wrap-around.
  - On the next cycle: grant_id=selected index, grant_valid=1, state=OWN, idle counter cleared.
- OWN:
  - slot_free = !tx_req || tx_ready.
  - req_ready[grant_id] = slot_free. All other req_ready bits are 0. req_ready is combinational from tx_ready and state.
  - On an accept (req_valid[g] && req_ready[g]), next cycle: tx_data=req_data[g], tx_req=1, idle counter cleared.
  - On an accept with req_last[g]=1: state=IDLE, grant_valid=0, rr_ptr=(g+1) mod NUM_REQ.
- Downstream handshake:
  - When tx_req && tx_ready with no new accept in the same cycle, tx_req goes to 0 on the next cycle.
  - A new accept in the same cycle as tx_ready reloads the register back-to-back. This gives 1 byte per cycle when tx_ready is held high.
- Latency:
  - req_valid first seen in IDLE at cycle t → grant_valid and req_ready at t+1 → tx_req at t+2 (when tx_req was 0).
- Timeout:
  - While in OWN, the idle counter increments every cycle that req_valid[g]=0. It saturates at IDLE_TIMEOUT.
  - Backpressure does not count as idle: cycles with req_valid high but slot_free low are not idle.
  - When the counter reaches IDLE_TIMEOUT: state=IDLE, grant_valid=0, rr_ptr=(g+1) mod NUM_REQ, and timeout_err=1 for exactly one cycle.
  - Any byte already in tx_data still completes.
- The transmit slot is independent of ownership:
  - A pending tx_req may still be outstanding after the grant is released.
  - The next owner's first byte waits for slot_free.
- Boundary conditions:
  - A requester releasing with req_valid still high gets lowest priority in the next arbitration.
  - A single active requester re-wins after the 1-cycle IDLE gap.
  - Changes in req_valid on non-granted ports while in OWN are ignored.
  - tx_data holds its last value when tx_req=0.
- A one-byte message (req_last on its first byte) is legal.

Test Plan:
- Single requester, message: req 1 sends 0x41, 0x42, 0x43 (last on 0x43), tx_ready held 1 → grant_id=1 one cycle after valid. tx_data shows 0x41, 0x42, 0x43 on consecutive cycles. grant_valid drops after 0x43. rr_ptr becomes 2.
- Fairness: reqs 0 and 2 each assert one-byte messages continuously from reset → grant sequence 0, 2, 0, 2, ….
- No interleaving: req 0 sends a 4-byte message while req 1 is valid throughout → all 4 bytes of req 0 appear before any byte of req 1. req_ready[1]=0 during req 0's grant.
- Backpressure: tx_ready=0 for 20 cycles after the first byte → tx_req stays 1 with tx_data stable. req_ready[g]=0. No timeout occurs, even with IDLE_TIMEOUT=8.
- Timeout: IDLE_TIMEOUT=8; req 3 sends 1 byte without last, then drops valid → timeout_err pulses exactly 8 idle cycles later. grant_valid goes to 0. Next arbitration starts from rr_ptr=0.
- Reset mid-message: assert reset_=0 while tx_req=1 and grant_valid=1 → tx_req, grant_valid and req_ready all 0 immediately, without waiting for a clock edge. After release, arbitration restarts from requester 0.
